// File: rtl/hf_pkg.sv
// Shared constants and helpers for the Hyperflex retiming bank.
// Sizes the per-channel depth field and limits out-of-range depth encodings.
package hf_pkg;

  localparam int HF_DEPTH_BYPASS = 0;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A depth field may encode more stages than exist; use the deepest one.
  function automatic int clamp_depth(input int field, input int max_depth);
    return (field > max_depth) ? max_depth : field;
  endfunction

endpackage

// File: rtl/hf_delay_line.sv
// One retiming channel: a free-running enable-qualified shift chain.
// The output taps the selected stage, or the raw input in bypass.
module hf_delay_line
  import hf_pkg::*;
#(
  parameter int MAX_DEPTH = 3
) (
  input  logic                              clk,
  input  logic                              clear_async_n,
  input  logic                              hf_en,
  input  logic                              din,
  input  logic [clog2(MAX_DEPTH + 1)-1:0]   depth,
  output logic                              dout
);

  localparam int DEPTH_BITS = clog2(MAX_DEPTH + 1);

  logic [MAX_DEPTH:1]    stage;
  logic [DEPTH_BITS-1:0] tap;

  // Stages shift independently of the selected tap so a depth change
  // immediately exposes real history.
  always_ff @(posedge clk or negedge clear_async_n) begin
    if (!clear_async_n) begin
      stage <= '0;
    end else if (hf_en) begin
      stage[1] <= din;
      for (int k = 2; k <= MAX_DEPTH; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  always_comb begin
    tap  = DEPTH_BITS'(clamp_depth(int'(depth), MAX_DEPTH));
    dout = din;
    if (tap != DEPTH_BITS'(HF_DEPTH_BYPASS)) begin
      for (int k = 1; k <= MAX_DEPTH; k++) begin
        if (tap == DEPTH_BITS'(k)) dout = stage[k];
      end
    end
  end

endmodule

// File: rtl/hf_retime_bank.sv
// Bank of WIDTH retiming channels with a serially loaded, shadowed depth
// configuration that only becomes active on a complete, committed load.
module hf_retime_bank
  import hf_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 3
) (
  input  logic             clk,
  input  logic             clear_async_n,
  input  logic             hf_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  input  logic             config_in,
  input  logic             config_en,
  input  logic             config_commit,
  output logic             config_out,
  output logic             config_full,
  output logic             config_err
);

  localparam int DEPTH_BITS = clog2(MAX_DEPTH + 1);
  localparam int CHAIN_LEN  = WIDTH * DEPTH_BITS;
  localparam int COUNT_BITS = clog2(CHAIN_LEN + 1);
  localparam logic [COUNT_BITS-1:0] COUNT_FULL = COUNT_BITS'(CHAIN_LEN);

  logic [CHAIN_LEN-1:0]  shadow;
  logic [CHAIN_LEN-1:0]  shadow_shifted;
  logic [CHAIN_LEN-1:0]  active;
  logic [COUNT_BITS-1:0] count;
  logic [COUNT_BITS-1:0] count_next;
  logic                  commit_ok;
  logic                  full_reg;
  logic                  err_reg;

  // Config protocol: config_commit outranks config_en in the same cycle, and
  // a commit is accepted only when exactly a full chain has been shifted.
  always_comb begin
    shadow_shifted = (shadow << 1) | CHAIN_LEN'(config_in);
    commit_ok      = config_commit && (count == COUNT_FULL);
    count_next     = count;
    if (config_commit) begin
      if (commit_ok) count_next = '0;
    end else if (config_en && (count != COUNT_FULL)) begin
      count_next = count + COUNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge clear_async_n) begin
    if (!clear_async_n) begin
      shadow   <= '0;
      active   <= '0;
      count    <= '0;
      full_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      if (commit_ok) active <= shadow;
      if (!config_commit && config_en) shadow <= shadow_shifted;
      count    <= count_next;
      full_reg <= (count_next == COUNT_FULL);
      err_reg  <= config_commit && !commit_ok;
    end
  end

  assign config_out  = shadow[CHAIN_LEN-1];
  assign config_full = full_reg;
  assign config_err  = err_reg;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    hf_delay_line #(
      .MAX_DEPTH (MAX_DEPTH)
    ) u_line (
      .clk           (clk),
      .clear_async_n (clear_async_n),
      .hf_en         (hf_en),
      .din           (data_in[i]),
      .depth         (active[i*DEPTH_BITS +: DEPTH_BITS]),
      .dout          (data_out[i])
    );
  end

endmodule

// File: tb/tb_hf_retime_bank.sv
// Bench for hf_retime_bank: two instances (MAX_DEPTH 3 and 2) share stimulus;
// a history-queue reference model predicts every cycle's outputs.
module tb_hf_retime_bank;

  localparam int WIDTH     = 8;
  localparam int CHAIN_LEN = 16;
  localparam int W         = 2 * WIDTH + 6;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             clear_async_n;
  logic             hf_en;
  logic [WIDTH-1:0] data_in;
  logic             config_in;
  logic             config_en;
  logic             config_commit;

  logic [WIDTH-1:0] do3, do2;
  logic             cout3, cout2, full3, full2, err3, err2;

  hf_retime_bank #(.WIDTH(WIDTH), .MAX_DEPTH(3)) u_dut3 (
    .clk           (clk),
    .clear_async_n (clear_async_n),
    .hf_en         (hf_en),
    .data_in       (data_in),
    .data_out      (do3),
    .config_in     (config_in),
    .config_en     (config_en),
    .config_commit (config_commit),
    .config_out    (cout3),
    .config_full   (full3),
    .config_err    (err3)
  );

  hf_retime_bank #(.WIDTH(WIDTH), .MAX_DEPTH(2)) u_dut2 (
    .clk           (clk),
    .clear_async_n (clear_async_n),
    .hf_en         (hf_en),
    .data_in       (data_in),
    .data_out      (do2),
    .config_in     (config_in),
    .config_en     (config_en),
    .config_commit (config_commit),
    .config_out    (cout2),
    .config_full   (full2),
    .config_err    (err2)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  string        phase    = "init";

  // reference model
  logic [CHAIN_LEN-1:0] m_shadow;
  logic [CHAIN_LEN-1:0] m_active;
  int                   m_count;
  logic                 m_err;
  logic [WIDTH-1:0]     m_hist[$];   // m_hist[n] = data_in captured n+1 enabled edges ago

  task automatic model_reset();
    m_shadow = '0;
    m_active = '0;
    m_count  = 0;
    m_err    = 1'b0;
    m_hist   = '{8'h00, 8'h00, 8'h00};
  endtask

  function automatic logic [WIDTH-1:0] model_dout(input logic [WIDTH-1:0] din, input int max_d);
    logic [WIDTH-1:0] r;
    int d;
    for (int i = 0; i < WIDTH; i++) begin
      d = int'(m_active[2*i +: 2]);
      if (d > max_d) d = max_d;
      r[i] = (d == 0) ? din[i] : m_hist[d-1][i];
    end
    return r;
  endfunction

  // driver: one clock cycle of stimulus, expectation, then the edge's effect
  task automatic step(input logic [WIDTH-1:0] din, input logic hen, input logic cin,
                      input logic cen, input logic ccommit, input logic rst_v = 1'b1);
    logic cfg_full;
    @(negedge clk);
    clear_async_n = rst_v;
    data_in       = din;
    hf_en         = hen;
    config_in     = cin;
    config_en     = cen;
    config_commit = ccommit;
    if (!rst_v) model_reset();
    cfg_full = (m_count == CHAIN_LEN);
    exp_q.push_back({model_dout(din, 3), model_dout(din, 2),
                     m_shadow[CHAIN_LEN-1], cfg_full, m_err,
                     m_shadow[CHAIN_LEN-1], cfg_full, m_err});
    if (rst_v) begin
      if (ccommit) begin
        if (m_count == CHAIN_LEN) begin
          m_active = m_shadow;
          m_count  = 0;
          m_err    = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end else begin
        m_err = 1'b0;
        if (cen) begin
          m_shadow = {m_shadow[CHAIN_LEN-2:0], cin};
          if (m_count < CHAIN_LEN) m_count++;
        end
      end
      if (hen) begin
        m_hist.push_front(din);
        void'(m_hist.pop_back());
      end
    end
  endtask

  task automatic idle(input int n, input logic hen);
    for (int k = 0; k < n; k++) step(8'($urandom), hen, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic shift_bits(input logic [CHAIN_LEN-1:0] w, input int nbits);
    for (int b = nbits - 1; b >= 0; b--) step(8'($urandom), 1'($urandom), w[b], 1'b1, 1'b0);
  endtask

  task automatic commit();
    step(8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1);
  endtask

  // monitor: compare every cycle against the oldest expectation
  initial begin
    logic [W-1:0] e, a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {do3, do2, cout3, full3, err3, cout2, full2, err2};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_check [%s] t=%0t: got do3=%h do2=%h out/full/err3=%b out/full/err2=%b, expected do3=%h do2=%h out/full/err3=%b out/full/err2=%b",
                   phase, $time, a[W-1 -: 8], a[W-9 -: 8], a[5:3], a[2:0],
                   e[W-1 -: 8], e[W-9 -: 8], e[5:3], e[2:0]);
        end
      end
    end
  end

  initial begin
    clear_async_n = 1'b0;
    hf_en         = 1'b0;
    data_in       = '0;
    config_in     = 1'b0;
    config_en     = 1'b0;
    config_commit = 1'b0;
    model_reset();

    phase = "reset";
    for (int k = 0; k < 3; k++)
      step(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    phase = "bypass";
    step(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b1);

    // ch0=1, ch1=3, ch3=3 (clamped to 2 on the MAX_DEPTH=2 instance)
    phase = "load_map";
    shift_bits(16'h00CD, 16);
    commit();
    phase = "pulse";
    step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h0B, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    phase = "short_commit";
    shift_bits(16'($urandom), 10);
    commit();
    idle(3, 1'b1);
    shift_bits(16'($urandom), 6);
    commit();
    idle(3, 1'b1);

    phase = "hold";
    shift_bits(16'h00CD, 16);
    commit();
    step(8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step((k % 2) ? 8'h02 : 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);

    phase = "commit_with_shift";
    shift_bits(16'h5A3C, 16);
    step(8'($urandom), 1'b1, 1'b1, 1'b1, 1'b1);
    commit();
    idle(3, 1'b1);

    phase = "random";
    for (int k = 0; k < 400; k++)
      step(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));

    phase = "readback";
    shift_bits(16'hC3A5, 16);
    commit();
    shift_bits(16'h0000, 16);
    idle(2, 1'b1);

    phase = "reset_mid_shift";
    shift_bits(16'hFFFF, 16);
    commit();
    shift_bits(16'hFFFF, 7);
    step(8'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    commit();
    idle(2, 1'b1);

    repeat (3) @(negedge clk);
    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hf_retime_bank.md
Name: hf_retime_bank

Overview:
- Parametrised Hyperflex retiming bank: WIDTH independent single-bit channels, each with a runtime-selectable register delay of 0..MAX_DEPTH.
- Generalises the fixed one-register, on/off HF unit found on ALM inputs and controls.
- Sits between routing and ALM/LAB inputs. Configured through a serial chain with a shadow register, explicit commit and error flagging.
- Everything, including the config chain, runs on one clock.

Parameters:
- WIDTH, 8, number of data channels.
- MAX_DEPTH, 3, maximum register stages per channel (>=1).
- DEPTH_BITS, derived as clog2(MAX_DEPTH+1), width of one channel's depth field. Not overridable.
- CHAIN_LEN, derived as WIDTH*DEPTH_BITS, config chain length in bits.

Ports:
- clk  input  1  sole clock; data path and config chain.
- clear_async_n  input  1  asynchronous active-low reset.
- hf_en  input  1  Hyperflex stage enable; delay stages advance only when 1.
- data_in  input  WIDTH  channel inputs.
- data_out  output  WIDTH  channel outputs.
- config_in  input  1  serial config bit.
- config_en  input  1  shift enable for the config chain.
- config_commit  input  1  copy shadow config into active config.
- config_out  output  1  serial chain output (shadow MSB), for daisy-chaining/readback.
- config_full  output  1  exactly CHAIN_LEN bits shifted since last commit/reset.
- config_err  output  1  one-cycle pulse on a rejected commit.

Behaviour:
- Reset (clear_async_n=0, async assert, sync deassert at clk edge): all delay stages, shadow, active config, shift count and config_err go to 0.
  - After reset every channel is depth 0 (bypass), so data_out = data_in.
  - config_out=0, config_full=0.
- Delay line per channel i: stages s[1..MAX_DEPTH].
  - On a clk edge with hf_en=1: s[1]<=data_in[i] and s[k]<=s[k-1].
  - With hf_en=0 all stages hold.
  - Stages always shift regardless of the selected depth.
- Output tap: d_i = active[i*DEPTH_BITS +: DEPTH_BITS], clamped to MAX_DEPTH if the field encodes a larger value.
  - d_i=0 gives data_out[i]=data_in[i], a combinational path.
  - Otherwise data_out[i]=s[d_i], i.e. data_in delayed by d_i hf_en-qualified edges.
- Depth change takes effect the cycle after commit with no flush. The new tap shows existing history, e.g. a 1->3 change exposes the value from 3 enabled edges ago.
- Shift: on config_en=1 (and config_commit=0), shadow <= {shadow[CHAIN_LEN-2:0], config_in}.
  - Shift count increments, saturating at CHAIN_LEN.
  - Extra shifts beyond CHAIN_LEN still shift the shadow; config_full stays 1.
  - config_out = shadow[CHAIN_LEN-1], registered.
- config_full = (count == CHAIN_LEN), registered.
- Commit (config_commit=1):
  - If count==CHAIN_LEN: active<=shadow and count<=0 on that edge. The shadow is retained, so it can be read back out through config_out.
  - Else: active and count unchanged, and config_err=1 for exactly the next cycle.
- config_commit and config_en together: commit wins and the shift is dropped that cycle. The count is not incremented.
- Back-to-back commits: the second is rejected (count=0) and raises config_err.
- Reset mid-shift or mid-operation: the chain is discarded and the bank returns to bypass.

Decomposition:
- Shared package hf_pkg:
  - clog2 function for DEPTH_BITS.
  - depth-field clamp function.
  - constant HF_DEPTH_BYPASS=0.
- Sub-module hf_delay_line: one channel. Parameter MAX_DEPTH; ports clk, clear_async_n, hf_en, din, depth, dout. Instantiated WIDTH times in a generate loop.
- The config shadow, active config, counter and commit/err logic live in the top.

Test Plan:
- Reset then drive data_in=8'hA5 -> data_out=8'hA5 combinationally; config_full=0, config_out=0.
- WIDTH=8, MAX_DEPTH=3: shift 16 bits so ch0=1, ch1=3, others 0, then commit. Pulse data_in[0] and data_in[1] high for one cycle with hf_en=1 -> data_out[0] high 1 cycle later, data_out[1] high 3 cycles later, ch2..7 unchanged-cycle pass-through.
- Shift 10 bits then commit -> config_err=1 for exactly one cycle, mapping unchanged. 6 more shifts then commit -> accepted, config_err stays 0.
- After a valid mapping: hold hf_en=0 for 5 cycles while toggling data_in[1] -> data_out[1] frozen; on resuming hf_en=1 the delayed sequence continues without loss.
- MAX_DEPTH=2, load a field of 2'b11 on ch3 and commit -> ch3 delay 2 (clamped). Commit with config_en=1 in the same cycle -> shadow unchanged and count cleared.
- Load pattern 16'hC3A5, commit, then shift 16 more zeros -> config_out emits 1100001110100101 MSB-first. Assert clear_async_n low mid-shift -> all outputs 0/bypass immediately.
